sr_drive_ctrl: RTL and testbench

SR_DRIVE_CTRL -- requirements
Module: sr_drive_ctrl

---
 rtl/sr_drive_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_sr_drive_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_drive_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sr_drive_ctrl
//  Purpose  : Drives S/R pulses into a downstream NOR SR latch on qualified
//             set/clear requests, then confirms the latch via its Q feedback.
//             Asynchronous inputs pass through 2-flop synchronizers and are
//             debounced before they can start an operation.
//  Ports    : clk      - single clock, rising edge
//             rst      - asynchronous active-high reset
//             set_req  - bouncy set request (async)
//             clr_req  - bouncy clear request (async)
//             q_fb     - Q of the driven latch (async)
//             s_out    - registered S drive pulse
//             r_out    - registered R drive pulse
//             busy     - high whenever the controller is not idle
//             done     - one-cycle pulse, feedback confirmed
//             err      - sticky: feedback timeout or conflicting requests
//  Revision : 1.0 - initial release
// ============================================================================
module sr_drive_ctrl #(
    parameter int unsigned DEB_CYCLES = 4,   // 1..15
    parameter int unsigned PULSE_W    = 3,   // 1..15
    parameter int unsigned TIMEOUT    = 8    // 1..255
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic clr_req,
    input  logic q_fb,
    output logic s_out,
    output logic r_out,
    output logic busy,
    output logic done,
    output logic err
);

    localparam logic [3:0] C_DEB_MAX    = 4'(DEB_CYCLES);
    localparam logic [3:0] C_DEB_LAST   = 4'(DEB_CYCLES - 1);
    localparam logic [3:0] C_PULSE_LAST = 4'(PULSE_W - 1);
    localparam logic [7:0] C_TO_LAST    = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE_S = 2'd1,
        ST_DRIVE_R = 2'd2,
        ST_WAIT_FB = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Request channels: bit 0 = set, bit 1 = clear
    // ------------------------------------------------------------------
    logic [1:0] w_req_raw;
    logic [1:0] w_req_evt;

    assign w_req_raw = {clr_req, set_req};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            logic [1:0] r_sync;
            logic [3:0] r_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync <= 2'b00;
                    r_cnt  <= 4'd0;
                end else begin
                    r_sync <= {r_sync[0], w_req_raw[gi]};
                    if (!r_sync[1]) begin
                        r_cnt <= 4'd0;
                    end else if (r_cnt != C_DEB_MAX) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
            end

            // Fires in the cycle whose closing edge moves the counter onto
            // DEB_CYCLES; once saturated the counter never revisits
            // DEB_CYCLES-1 while the input stays high, so a held request
            // produces a single event.
            assign w_req_evt[gi] = r_sync[1] && (r_cnt == C_DEB_LAST);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Latch feedback synchronizer
    // ------------------------------------------------------------------
    logic [1:0] r_q_sync;
    logic       w_q_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q_sync <= 2'b00;
        end else begin
            r_q_sync <= {r_q_sync[0], q_fb};
        end
    end

    assign w_q_s = r_q_sync[1];

    // ------------------------------------------------------------------
    // Control FSM, all outputs registered
    // ------------------------------------------------------------------
    state_t     r_state;
    logic       r_s_out;
    logic       r_r_out;
    logic       r_busy;
    logic       r_done;
    logic       r_err;
    logic       r_target;
    logic [3:0] r_pulse_cnt;
    logic [7:0] r_to_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_s_out     <= 1'b0;
            r_r_out     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_target    <= 1'b0;
            r_pulse_cnt <= 4'd0;
            r_to_cnt    <= 8'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Events are only looked at here, so anything that
                    // qualifies while busy is simply lost.
                    if (w_req_evt[0] && w_req_evt[1]) begin
                        r_err <= 1'b1;
                    end else if (w_req_evt[0]) begin
                        r_state     <= ST_DRIVE_S;
                        r_s_out     <= 1'b1;
                        r_busy      <= 1'b1;
                        r_err       <= 1'b0;
                        r_target    <= 1'b1;
                        r_pulse_cnt <= 4'd0;
                    end else if (w_req_evt[1]) begin
                        r_state     <= ST_DRIVE_R;
                        r_r_out     <= 1'b1;
                        r_busy      <= 1'b1;
                        r_err       <= 1'b0;
                        r_target    <= 1'b0;
                        r_pulse_cnt <= 4'd0;
                    end
                end
                ST_DRIVE_S, ST_DRIVE_R: begin
                    if (r_pulse_cnt == C_PULSE_LAST) begin
                        r_state  <= ST_WAIT_FB;
                        r_s_out  <= 1'b0;
                        r_r_out  <= 1'b0;
                        r_to_cnt <= 8'd0;
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt + 4'd1;
                    end
                end
                ST_WAIT_FB: begin
                    // r_to_cnt counts WAIT_FB cycles already spent without
                    // a match; the TIMEOUT-th cycle is the last chance.
                    if (w_q_s == r_target) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_to_cnt == C_TO_LAST) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_out = r_s_out;
    assign r_out = r_r_out;
    assign busy  = r_busy;
    assign done  = r_done;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sr_drive_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sr_drive_ctrl
//  Purpose  : Scoreboard bench for sr_drive_ctrl. Each operation computes the
//             output edges it should cause (which output, rising/falling, at
//             which cycle) from request timing and a behavioural latch, and
//             queues them; a monitor pops and compares every observed edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sr_drive_ctrl;

    localparam int DEB = 4;
    localparam int PW  = 3;
    localparam int TO  = 8;

    // Edge kinds: signal j rising = 2*j, falling = 2*j+1,
    // signals ordered s_out, r_out, done, err, busy.
    localparam int K_S_ON     = 0;
    localparam int K_S_OFF    = 1;
    localparam int K_R_ON     = 2;
    localparam int K_R_OFF    = 3;
    localparam int K_DONE_ON  = 4;
    localparam int K_DONE_OFF = 5;
    localparam int K_ERR_ON   = 6;
    localparam int K_ERR_OFF  = 7;
    localparam int K_BUSY_ON  = 8;
    localparam int K_BUSY_OFF = 9;

    logic clk = 1'b0;
    logic rst;
    logic set_req;
    logic clr_req;
    logic q_fb;
    logic s_out;
    logic r_out;
    logic busy;
    logic done;
    logic err;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t exp_q[$];

    // Behavioural latch and model state
    bit model_q;
    bit model_err;
    int latch_d;
    bit latch_stuck;
    int s_age;
    int r_age;

    sr_drive_ctrl #(
        .DEB_CYCLES(DEB),
        .PULSE_W   (PW),
        .TIMEOUT   (TO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .set_req(set_req),
        .clr_req(clr_req),
        .q_fb   (q_fb),
        .s_out  (s_out),
        .r_out  (r_out),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assert property (@(posedge clk) disable iff (rst) !(s_out && r_out))
        else $error("FAIL drive_mutex_assert: s_out and r_out both high");

    function automatic string kname(input int k);
        case (k)
            K_S_ON:     return "s_out_rise";
            K_S_OFF:    return "s_out_fall";
            K_R_ON:     return "r_out_rise";
            K_R_OFF:    return "r_out_fall";
            K_DONE_ON:  return "done_rise";
            K_DONE_OFF: return "done_fall";
            K_ERR_ON:   return "err_rise";
            K_ERR_OFF:  return "err_fall";
            K_BUSY_ON:  return "busy_rise";
            K_BUSY_OFF: return "busy_fall";
            default:    return "unknown";
        endcase
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Keep the queue ordered by (cycle, kind) so the monitor can pop in order.
    task automatic push(input int k, input int c);
        ev_t e;
        int  idx;
        e.kind = k;
        e.cyc  = c;
        idx    = exp_q.size();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].cyc > c || (exp_q[i].cyc == c && exp_q[i].kind > k)) begin
                idx = i;
                break;
            end
        end
        exp_q.insert(idx, e);
    endtask

    task automatic observe(input int k);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0 || exp_q[0].cyc > cyc) begin
            $display("FAIL event: got %s at cycle %0d, expected no edge", kname(k), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == k && e.cyc == cyc) n_pass++;
            else $display("FAIL event: got %s at cycle %0d, expected %s at cycle %0d",
                          kname(k), cyc, kname(e.kind), e.cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: turns output edges into events and scores them
    // ------------------------------------------------------------------
    initial begin : monitor
        logic [4:0] prev;
        logic [4:0] cur;
        ev_t        e;
        prev = 5'b0;
        forever begin
            @(negedge clk);
            cur = {busy, err, done, r_out, s_out};
            for (int j = 0; j < 5; j++) begin
                if (cur[j] != prev[j]) observe(cur[j] ? 2 * j : 2 * j + 1);
            end
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                n_checks++;
                $display("FAIL event: got nothing by cycle %0d, expected %s at cycle %0d",
                         cyc, kname(e.kind), e.cyc);
            end
            if (s_out || r_out) check("drive_mutex", int'(s_out & r_out), 0);
            prev = cur;
        end
    end

    // ------------------------------------------------------------------
    // Behavioural NOR latch: Q follows a drive D cycles into the pulse
    // ------------------------------------------------------------------
    initial begin : latch
        s_age = 0;
        r_age = 0;
        forever begin
            @(negedge clk);
            s_age = s_out ? s_age + 1 : 0;
            r_age = r_out ? r_age + 1 : 0;
            if (!latch_stuck) begin
                if (s_age > latch_d)      q_fb = 1'b1;
                else if (r_age > latch_d) q_fb = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model of one accepted drive starting at cycle t1
    // ------------------------------------------------------------------
    task automatic expect_drive(input bit tgt, input int t1,
                                output int busy_off, output int last);
        int w;
        bit match;
        push(tgt ? K_S_ON : K_R_ON, t1);
        push(K_BUSY_ON, t1);
        if (model_err) begin
            push(K_ERR_OFF, t1);
            model_err = 1'b0;
        end
        push(tgt ? K_S_OFF : K_R_OFF, t1 + PW);
        // Feedback is seen through two sync flops; the first WAIT_FB cycle
        // follows the pulse's last cycle.
        w     = t1 + PW;
        match = 1'b1;
        if (model_q != tgt) begin
            if (latch_stuck) match = 1'b0;
            else begin
                w     = imax(t1 + PW, t1 + latch_d + 2);
                match = (w <= t1 + PW + TO - 1);
            end
        end
        if (match) begin
            push(K_DONE_ON, w + 1);
            push(K_DONE_OFF, w + 2);
            push(K_BUSY_OFF, w + 1);
            model_q  = tgt;
            busy_off = w + 1;
            last     = w + 2;
        end else begin
            push(K_ERR_ON, t1 + PW + TO);
            push(K_BUSY_OFF, t1 + PW + TO);
            model_err = 1'b1;
            busy_off  = t1 + PW + TO;
            last      = t1 + PW + TO;
        end
    endtask

    task automatic drive(input bit tgt, input logic v);
        if (tgt) set_req = v;
        else     clr_req = v;
    endtask

    // Drives set/clr high inside [s0,s1) / [c0,c1) (cycle numbers) until fin.
    task automatic run_windows(input int s0, input int s1, input int c0, input int c1, input int fin);
        while (cyc < fin) begin
            set_req = (cyc >= s0 && cyc < s1);
            clr_req = (cyc >= c0 && cyc < c1);
            @(negedge clk);
        end
        set_req = 1'b0;
        clr_req = 1'b0;
    endtask

    // Single request, optionally with the opposite request qualifying
    // while busy, optionally with a latch that ignores the drive.
    task automatic op_req(input bit tgt, input bit inject, input bit stuck);
        int n, t1, boff, last, h, m, h2, p0, p1, o0, o1, fin;
        n           = cyc;
        latch_stuck = stuck;
        latch_d     = int'($urandom_range(PW - 1, 0));
        t1          = n + 2 + DEB;
        expect_drive(tgt, t1, boff, last);
        h  = DEB + 2 + int'($urandom_range(12, 0));
        p0 = n;
        p1 = n + h;
        o0 = 0;
        o1 = 0;
        if (inject) begin
            // Opposite event lands on an edge in [t1+1, boff]: FSM busy.
            m  = int'($urandom_range(boff - 2 - DEB, n + 1));
            h2 = DEB + 2 + int'($urandom_range(8, 0));
            o0 = m;
            o1 = m + h2;
        end
        fin = imax(last, imax(p1, o1)) + 4;
        if (tgt) run_windows(p0, p1, o0, o1, fin);
        else     run_windows(o0, o1, p0, p1, fin);
        latch_stuck = 1'b0;
    endtask

    task automatic op_both();
        int n, h;
        n = cyc;
        h = DEB + 2 + int'($urandom_range(8, 0));
        if (!model_err) push(K_ERR_ON, n + 2 + DEB);
        model_err = 1'b1;
        run_windows(n, n + h, n, n + h, n + h + 4);
    endtask

    // Bursts shorter than DEB, separated by lows: never qualifies.
    task automatic op_glitch(input bit tgt, input bit directed);
        int nb, hi, lo;
        nb = directed ? 2 : int'($urandom_range(3, 2));
        for (int b = 0; b < nb; b++) begin
            hi = directed ? 3 : int'($urandom_range(DEB - 1, 1));
            lo = directed ? 1 : int'($urandom_range(3, 1));
            drive(tgt, 1'b1);
            repeat (hi) @(negedge clk);
            drive(tgt, 1'b0);
            repeat (lo) @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    // Reset during the 2nd drive cycle, request held through and after it.
    task automatic op_reset(input bit tgt);
        int n, t1, r, boff, last;
        latch_stuck = 1'b0;
        latch_d     = int'($urandom_range(PW - 1, 0));
        n           = cyc;
        t1          = n + 2 + DEB;
        push(tgt ? K_S_ON : K_R_ON, t1);
        push(K_BUSY_ON, t1);
        if (model_err) begin
            push(K_ERR_OFF, t1);
            model_err = 1'b0;
        end
        drive(tgt, 1'b1);
        while (cyc < t1 + 1) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_s_out", int'(s_out), 0);
        check("rst_async_r_out", int'(r_out), 0);
        check("rst_async_busy", int'(busy), 0);
        check("rst_async_done", int'(done), 0);
        check("rst_async_err", int'(err), 0);
        push(tgt ? K_S_OFF : K_R_OFF, t1 + 2);
        push(K_BUSY_OFF, t1 + 2);
        if (latch_d <= 1) model_q = tgt;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        r   = cyc;
        expect_drive(tgt, r + 2 + DEB, boff, last);
        while (cyc < r + DEB + 4) @(negedge clk);
        drive(tgt, 1'b0);
        while (cyc < imax(last, r + DEB + 4) + 4) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin : stim
        int sel;
        rst         = 1'b1;
        set_req     = 1'b0;
        clr_req     = 1'b0;
        q_fb        = 1'b0;
        model_q     = 1'b0;
        model_err   = 1'b0;
        latch_d     = 0;
        latch_stuck = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_s_out", int'(s_out), 0);
        check("reset_r_out", int'(r_out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_err", int'(err), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        op_req(1'b1, 1'b0, 1'b0);   // plain set, latch follows
        op_glitch(1'b1, 1'b1);      // 3 high, 1 low, 3 high
        op_both();                  // conflict -> err
        op_req(1'b0, 1'b0, 1'b0);   // lone clear clears err
        op_req(1'b1, 1'b0, 1'b0);   // bring Q to 1
        op_req(1'b0, 1'b0, 1'b1);   // clear with Q stuck at 1 -> timeout
        op_reset(1'b1);             // reset mid-pulse, requalify
        op_req(1'b1, 1'b1, 1'b0);   // clear qualifies while set is busy

        for (int i = 0; i < 30; i++) begin
            sel = int'($urandom_range(9, 0));
            if (sel <= 4)      op_req(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                                      ($urandom_range(3, 0) == 0));
            else if (sel <= 6) op_glitch(1'($urandom_range(1, 0)), 1'b0);
            else if (sel == 7) op_both();
            else if (sel == 8) op_reset(1'($urandom_range(1, 0)));
            else               op_req(1'($urandom_range(1, 0)), 1'b0, 1'b0);
        end

        repeat (10) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
